lc3b_store_buffer: RTL and testbench

//  4-entry FIFO store buffer between the LC-3b datapath and physical memory; posts stores, drains in order.

---
 rtl/lc3b_store_buffer_pkg.sv | 28 ++
 rtl/lc3b_sb_fwd_match.sv | 35 +++
 rtl/lc3b_store_buffer.sv | 101 ++++++++++
 tb/tb_lc3b_store_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_store_buffer_pkg.sv
// rtl/lc3b_store_buffer_pkg.sv - shared types and constants for the LC-3b store buffer
package lc3b_store_buffer_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = 2;

  typedef logic [SB_PTR_W-1:0] lc3b_sb_ptr;

  typedef struct packed {
    lc3b_word      addr;
    lc3b_word      data;
    lc3b_mem_wmask wmask;
  } lc3b_sb_entry;

  // Drain FSM encoding kept as plain constants for the legacy counter logic
  typedef logic sb_state_t;
  localparam sb_state_t SB_IDLE  = 1'b0;
  localparam sb_state_t SB_ISSUE = 1'b1;

  // One-hot slot select for the downstream drain counter
  function automatic logic [SB_DEPTH-1:0] sb_onehot(input lc3b_sb_ptr p);
    return SB_DEPTH'(1) << p;
  endfunction

endpackage

// File: rtl/lc3b_sb_fwd_match.sv
// rtl/lc3b_sb_fwd_match.sv - youngest-first load forwarding match (used when SB_FWD_EN is defined)
module lc3b_sb_fwd_match
  import lc3b_store_buffer_pkg::*;
(
  input  lc3b_sb_entry entries [SB_DEPTH],
  input  lc3b_sb_ptr   tail,
  input  logic [2:0]   count,
  input  lc3b_word     ld_addr,
  output logic         fwd_hit,
  output lc3b_word     fwd_data
);

  logic       found;
  lc3b_sb_ptr idx;

  // Walk from the youngest entry back; the first address match decides,
  // and a partial-mask match blocks forwarding from anything older.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = tail - lc3b_sb_ptr'(i + 1);
      if (!found && (3'(i) < count) && (entries[idx].addr == ld_addr)) begin
        found   = 1'b1;
        fwd_hit = (entries[idx].wmask == 2'b11);
        if (entries[idx].wmask == 2'b11) begin
          fwd_data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/lc3b_store_buffer.sv
// rtl/lc3b_store_buffer.sv - 4-entry in-order store buffer; SB_FWD_EN adds load forwarding
module lc3b_store_buffer
  import lc3b_store_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  input  logic [1:0]  st_mask,
  output logic        st_ready,
  output logic        pmem_write,
  output logic [15:0] pmem_addr,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic        pmem_resp,
  output logic [3:0]  drain_sel,
  output logic        drain_inc,
  output logic        empty,
  output logic [2:0]  count
`ifdef SB_FWD_EN
  ,
  input  logic [15:0] ld_addr,
  output logic        fwd_hit,
  output logic [15:0] fwd_data
`endif
);

  lc3b_sb_entry entries [SB_DEPTH];
  lc3b_sb_ptr   head;
  lc3b_sb_ptr   tail;
  logic [2:0]   count_q;
  logic [2:0]   count_next;
  sb_state_t    state;
  logic         drain_inc_q;
  logic         push;
  logic         pop;

  assign st_ready = (count_q != 3'd4);
  assign push     = st_valid && st_ready;
  assign pop      = (state == SB_ISSUE) && pmem_resp;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + 3'd1;
    end else if (pop && !push) begin
      count_next = count_q - 3'd1;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every use
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: st_addr, data: st_data, wmask: st_mask};
    end
  end

  // Pointers, occupancy, drain FSM and the registered retire pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      state       <= SB_IDLE;
      drain_inc_q <= 1'b0;
    end else begin
      if (push) tail <= tail + lc3b_sb_ptr'(1);
      if (pop)  head <= head + lc3b_sb_ptr'(1);
      count_q     <= count_next;
      drain_inc_q <= pop;
      if (state == SB_IDLE) begin
        if (count_q != 3'd0) state <= SB_ISSUE;
      end else begin
        if (count_next == 3'd0) state <= SB_IDLE;
      end
    end
  end

  assign pmem_write = (state == SB_ISSUE);
  assign pmem_addr  = entries[head].addr;
  assign pmem_wdata = entries[head].data;
  assign pmem_wmask = entries[head].wmask;
  assign drain_sel  = pmem_write ? sb_onehot(head) : 4'b0000;
  assign drain_inc  = drain_inc_q;
  assign empty      = (count_q == 3'd0);
  assign count      = count_q;

`ifdef SB_FWD_EN
  lc3b_sb_fwd_match u_fwd (
    .entries  (entries),
    .tail     (tail),
    .count    (count_q),
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );
`endif

endmodule

// File: tb/tb_lc3b_store_buffer.sv
// tb/tb_lc3b_store_buffer.sv - scoreboard bench for lc3b_store_buffer (SB_FWD_EN optional)
module tb_lc3b_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic [1:0]  st_mask;
  logic        st_ready;
  logic        pmem_write;
  logic [15:0] pmem_addr;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_resp;
  logic [3:0]  drain_sel;
  logic        drain_inc;
  logic        empty;
  logic [2:0]  count;
  logic [15:0] ld_addr;
`ifdef SB_FWD_EN
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  lc3b_store_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_mask    (st_mask),
    .st_ready   (st_ready),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_wmask (pmem_wmask),
    .pmem_resp  (pmem_resp),
    .drain_sel  (drain_sel),
    .drain_inc  (drain_inc),
    .empty      (empty),
    .count      (count)
`ifdef SB_FWD_EN
    ,
    .ld_addr    (ld_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } st_t;

  st_t live_q[$];   // reference contents, oldest first
  st_t store_q[$];  // accepted stores awaiting retirement, program order
  st_t e;
  int  errors = 0;
  int  checks = 0;
  int  mprev  = 0;  // model occupancy during the previous cycle
  int  mslot  = 0;  // slot index of the oldest entry
  bit  pop_last = 0;
  bit  started  = 0;
  int  mc;
  bit  pu, po;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write is outstanding whenever the buffer held data in
  // both this cycle and the previous one; pushes refused at 4 entries.
  always @(posedge clk) begin
    if (!rst_n) begin
      live_q.delete();
      store_q.delete();
      mprev    = 0;
      mslot    = 0;
      pop_last = 0;
      started  = 1;
    end else if (started) begin
      mc = live_q.size();
      pu = st_valid && (mc < 4);
      po = (mc > 0) && (mprev > 0) && pmem_resp;
      if (po) begin
        void'(live_q.pop_front());
        mslot = (mslot + 1) % 4;
      end
      if (pu) begin
        e.a = st_addr; e.d = st_data; e.m = st_mask;
        live_q.push_back(e);
        store_q.push_back(e);
      end
      pop_last = po;
      mprev    = mc;
    end
  end

  // Monitor: status against the model, retirements against the scoreboard
  always @(negedge clk) begin
    int  c;
    bit  ewr;
    st_t h;
    if (started) begin
      c   = live_q.size();
      ewr = (c > 0) && (mprev > 0);
      chk("count",      32'(count),      32'(c));
      chk("empty",      32'(empty),      32'(c == 0));
      chk("st_ready",   32'(st_ready),   32'(c < 4));
      chk("pmem_write", 32'(pmem_write), 32'(ewr));
      chk("drain_sel",  32'(drain_sel),  ewr ? (32'd1 << mslot) : 32'd0);
      chk("drain_inc",  32'(drain_inc),  32'(pop_last));
`ifdef SB_FWD_EN
      begin
        bit          xh = 0;
        logic [15:0] xd = '0;
        for (int i = c - 1; i >= 0; i--) begin
          if (live_q[i].a == ld_addr) begin
            xh = (live_q[i].m == 2'b11);
            xd = xh ? live_q[i].d : 16'h0;
            break;
          end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(xh));
        if (xh) chk("fwd_data", 32'(fwd_data), 32'(xd));
      end
`endif
      if (rst_n && pmem_write && pmem_resp) begin
        if (store_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire: got write with no pending store, expected none at %0t", $time);
        end else begin
          h = store_q.pop_front();
          chk("retire_addr", 32'(pmem_addr),  32'(h.a));
          chk("retire_data", 32'(pmem_wdata), 32'(h.d));
          chk("retire_mask", 32'(pmem_wmask), 32'(h.m));
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] m, input bit resp);
    rst_n = r; st_valid = v; st_addr = a; st_data = d; st_mask = m; pmem_resp = resp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit resp);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, resp);
  endtask

  initial begin
    ld_addr = 16'h4000;
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);

    // single store, late response
    cyc(1'b1, 1'b1, 16'h3000, 16'hBEEF, 2'b11, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // fill to four, fifth refused, then drain one per cycle
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 16'h5000 + 16'(i * 2), 16'hA000 + 16'(i), 2'b11, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);
    idle(2, 1'b0);

    // six stores over time so the tail wraps
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 16'h6000 + 16'(i * 2), 16'hC000 + 16'(i), 2'(i), 1'b0);
      idle(1, 1'b1);
    end
    idle(4, 1'b1);

    // push and pop in the same cycle at occupancy two
    cyc(1'b1, 1'b1, 16'h7000, 16'h1111, 2'b11, 1'b0);
    cyc(1'b1, 1'b1, 16'h7002, 16'h2222, 2'b10, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 1'b1, 16'h7004, 16'h3333, 2'b01, 1'b1);
    idle(5, 1'b1);

    // reset while a write is outstanding; late responses must be ignored
    cyc(1'b1, 1'b1, 16'h7100, 16'h4444, 2'b11, 1'b0);
    cyc(1'b1, 1'b1, 16'h7102, 16'h5555, 2'b11, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
    idle(3, 1'b1);

    // forwarding: full match, then a younger partial store blocks it
    ld_addr = 16'h4000;
    cyc(1'b1, 1'b1, 16'h4000, 16'h1234, 2'b11, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 1'b1, 16'h4000, 16'h5678, 2'b01, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      ld_addr = 16'h4000 + 16'($urandom_range(0, 3) * 2);
      cyc(($urandom_range(0, 63) != 0), 1'($urandom),
          16'h4000 + 16'($urandom_range(0, 3) * 2), 16'($urandom),
          2'($urandom), ($urandom_range(0, 2) != 0));
    end
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
